inst_decode: RTL and testbench

Instruction-decode stage of the KGP-RISC five-stage pipeline, directly downstream of instruction fetch. Consumes the IF/ID instruction word and next-PC, reads the 32×32 register file and decodes control fields. Registers the results into the ID/EX pipeline register. Owns load-use hazard detection (stall back to fetch), branch-squash bubbling and the writeback port of the register file.

---
 rtl/inst_decode.sv | 179 +++++++++++++++++
 tb/tb_inst_decode.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_decode.sv
// KGP-RISC ID stage: register file, control decode, load-use stall and branch squash.
// Define REG_BYPASS_EN to forward a same-cycle writeback to the register read ports.
module inst_decode #(
  parameter int unsigned PC_W          = 10,
  parameter int unsigned SQUASH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     if_id_instr,
  input  logic [PC_W-1:0] if_id_NPC,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [31:0]     wb_data,
  output logic            stall,
  output logic            id_ex_valid,
  output logic [PC_W-1:0] id_ex_NPC,
  output logic [31:0]     id_ex_rs_data,
  output logic [31:0]     id_ex_rt_data,
  output logic [31:0]     id_ex_imm,
  output logic [4:0]      id_ex_rs,
  output logic [4:0]      id_ex_rt,
  output logic [4:0]      id_ex_dst,
  output logic [5:0]      id_ex_alu_op,
  output logic            id_ex_reg_write,
  output logic            id_ex_mem_read,
  output logic            id_ex_mem_write,
  output logic            id_ex_branch,
  output logic            id_ex_jump,
  output logic            id_ex_alu_src,
  output logic            id_ex_illegal
);

  localparam logic [5:0] OpR    = 6'h00;
  localparam logic [5:0] OpAddi = 6'h01;
  localparam logic [5:0] OpLw   = 6'h02;
  localparam logic [5:0] OpSw   = 6'h03;
  localparam logic [5:0] OpBz   = 6'h04;
  localparam logic [5:0] OpJ    = 6'h05;
  localparam logic [1:0] SqLoad = 2'(SQUASH_CYCLES - 1);

  logic [31:0] regs [32];
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rs_val, rt_val, imm;
  logic [4:0]  dst;
  logic [5:0]  alu_op;
  logic        rw, mr, mw, br, jp, as, ill, uses_rt;
  logic        hazard, bubble;
  logic [1:0]  sq_cnt_q, sq_cnt_d;

  assign opcode = if_id_instr[31:26];
  assign rs     = if_id_instr[25:21];
  assign rt     = if_id_instr[20:16];
  assign rd     = if_id_instr[15:11];

  always_comb begin
    rs_val = regs[rs];
    rt_val = regs[rt];
`ifdef REG_BYPASS_EN
    if (wb_en && (wb_addr != 5'd0) && (wb_addr == rs)) rs_val = wb_data;
    if (wb_en && (wb_addr != 5'd0) && (wb_addr == rt)) rt_val = wb_data;
`endif
    if (rs == 5'd0) rs_val = '0;
    if (rt == 5'd0) rt_val = '0;
  end

  always_comb begin
    dst     = '0;
    alu_op  = '0;
    rw      = 1'b0;
    mr      = 1'b0;
    mw      = 1'b0;
    br      = 1'b0;
    jp      = 1'b0;
    as      = 1'b0;
    ill     = 1'b0;
    uses_rt = 1'b0;
    imm     = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
    case (opcode)
      OpR: begin
        dst     = rd;
        rw      = 1'b1;
        alu_op  = if_id_instr[5:0];
        uses_rt = 1'b1;
      end
      OpAddi: begin
        dst    = rt;
        as     = 1'b1;
        rw     = 1'b1;
        alu_op = opcode;
      end
      OpLw: begin
        dst    = rt;
        as     = 1'b1;
        mr     = 1'b1;
        rw     = 1'b1;
        alu_op = opcode;
      end
      OpSw: begin
        mw      = 1'b1;
        as      = 1'b1;
        uses_rt = 1'b1;
        alu_op  = opcode;
      end
      OpBz: begin
        br     = 1'b1;
        alu_op = opcode;
      end
      OpJ: begin
        jp     = 1'b1;
        imm    = {22'b0, if_id_instr[9:0]};
        alu_op = opcode;
      end
      default: ill = 1'b1;
    endcase
  end

  assign hazard = id_ex_valid && id_ex_mem_read && (id_ex_dst != 5'd0) &&
                  ((id_ex_dst == rs) || (uses_rt && (id_ex_dst == rt)));
  // A redirect in flight makes the stalled instruction dead, so never hold fetch then.
  assign stall  = hazard && !flush && (sq_cnt_q == 2'd0);
  assign bubble = flush || (sq_cnt_q != 2'd0) || stall;

  always_comb begin
    sq_cnt_d = sq_cnt_q;
    if (flush) sq_cnt_d = SqLoad;
    else if (sq_cnt_q != 2'd0) sq_cnt_d = sq_cnt_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_cnt_q        <= '0;
      id_ex_valid     <= 1'b0;
      id_ex_NPC       <= '0;
      id_ex_rs_data   <= '0;
      id_ex_rt_data   <= '0;
      id_ex_imm       <= '0;
      id_ex_rs        <= '0;
      id_ex_rt        <= '0;
      id_ex_dst       <= '0;
      id_ex_alu_op    <= '0;
      id_ex_reg_write <= 1'b0;
      id_ex_mem_read  <= 1'b0;
      id_ex_mem_write <= 1'b0;
      id_ex_branch    <= 1'b0;
      id_ex_jump      <= 1'b0;
      id_ex_alu_src   <= 1'b0;
      id_ex_illegal   <= 1'b0;
    end else begin
      sq_cnt_q        <= sq_cnt_d;
      id_ex_valid     <= !bubble;
      id_ex_NPC       <= bubble ? '0 : if_id_NPC;
      id_ex_rs_data   <= bubble ? '0 : rs_val;
      id_ex_rt_data   <= bubble ? '0 : rt_val;
      id_ex_imm       <= bubble ? '0 : imm;
      id_ex_rs        <= bubble ? '0 : rs;
      id_ex_rt        <= bubble ? '0 : rt;
      id_ex_dst       <= bubble ? '0 : dst;
      id_ex_alu_op    <= bubble ? '0 : alu_op;
      id_ex_reg_write <= !bubble && rw;
      id_ex_mem_read  <= !bubble && mr;
      id_ex_mem_write <= !bubble && mw;
      id_ex_branch    <= !bubble && br;
      id_ex_jump      <= !bubble && jp;
      id_ex_alu_src   <= !bubble && as;
      id_ex_illegal   <= !bubble && ill;
    end
  end

endmodule

// File: tb/tb_inst_decode.sv
// Scoreboard bench for inst_decode: expected ID/EX contents queued on drive, popped after the edge.
module tb_inst_decode;
  localparam int unsigned PC_W = 10;
  localparam logic [6:0] RW = 7'h40, MR = 7'h20, MW = 7'h10, BR = 7'h08, JP = 7'h04,
                         AS = 7'h02, IL = 7'h01;
  localparam logic [31:0] ILL = 32'hFC00_0000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [31:0]     if_id_instr = '0;
  logic [PC_W-1:0] if_id_NPC = '0;
  logic            flush = 1'b0, wb_en = 1'b0;
  logic [4:0]      wb_addr = '0;
  logic [31:0]     wb_data = '0;
  logic            stall, id_ex_valid;
  logic [PC_W-1:0] id_ex_NPC;
  logic [31:0]     id_ex_rs_data, id_ex_rt_data, id_ex_imm;
  logic [4:0]      id_ex_rs, id_ex_rt, id_ex_dst;
  logic [5:0]      id_ex_alu_op;
  logic id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_branch, id_ex_jump;
  logic id_ex_alu_src, id_ex_illegal;

  always #5 clk = ~clk;

  inst_decode #(.PC_W(PC_W), .SQUASH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .if_id_instr(if_id_instr), .if_id_NPC(if_id_NPC),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall),
    .id_ex_valid(id_ex_valid), .id_ex_NPC(id_ex_NPC), .id_ex_rs_data(id_ex_rs_data),
    .id_ex_rt_data(id_ex_rt_data), .id_ex_imm(id_ex_imm), .id_ex_rs(id_ex_rs),
    .id_ex_rt(id_ex_rt), .id_ex_dst(id_ex_dst), .id_ex_alu_op(id_ex_alu_op),
    .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_mem_write(id_ex_mem_write), .id_ex_branch(id_ex_branch), .id_ex_jump(id_ex_jump),
    .id_ex_alu_src(id_ex_alu_src), .id_ex_illegal(id_ex_illegal)
  );

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] npc;
    logic [31:0]     rs_data;
    logic [31:0]     rt_data;
    logic [31:0]     imm;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      dst;
    logic [5:0]      alu_op;
    logic [6:0]      ctrl;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic        fl;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    exp_t        e;
    logic        es;
  } step_t;

  localparam exp_t BUB = '0;

  exp_t            sb[$];
  int              n_cmp = 0, n_bad = 0;
  logic [PC_W-1:0] pc_ctr = '0;
  exp_t            got, want;

  function automatic exp_t obs();
    exp_t o;
    o.valid = id_ex_valid; o.npc = id_ex_NPC; o.rs_data = id_ex_rs_data;
    o.rt_data = id_ex_rt_data; o.imm = id_ex_imm; o.rs = id_ex_rs; o.rt = id_ex_rt;
    o.dst = id_ex_dst; o.alu_op = id_ex_alu_op;
    o.ctrl = {id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_branch, id_ex_jump,
              id_ex_alu_src, id_ex_illegal};
    return o;
  endfunction

  function automatic exp_t dec(input logic [31:0] rsd, input logic [31:0] rtd,
                               input logic [31:0] imm, input logic [4:0] dst,
                               input logic [5:0] op, input logic [6:0] ctrl);
    exp_t e = '0;
    e.valid = 1'b1; e.rs_data = rsd; e.rt_data = rtd; e.imm = imm;
    e.dst = dst; e.alu_op = op; e.ctrl = ctrl;
    return e;
  endfunction

  function automatic step_t mk(input logic [31:0] instr, input logic fl, input logic we,
                               input logic [4:0] wa, input logic [31:0] wd, input exp_t e,
                               input logic es);
    step_t s;
    s.instr = instr; s.fl = fl; s.we = we; s.wa = wa; s.wd = wd; s.e = e; s.es = es;
    return s;
  endfunction

  task automatic drive(input step_t s);
    exp_t e = s.e;
    if_id_instr = s.instr; flush = s.fl; wb_en = s.we; wb_addr = s.wa; wb_data = s.wd;
    pc_ctr = pc_ctr + 1'b1;
    if_id_NPC = pc_ctr;
    if (e.valid) begin
      e.npc = pc_ctr; e.rs = s.instr[25:21]; e.rt = s.instr[20:16];
    end
    sb.push_back(e);
  endtask

  task automatic test_reset();
    step_t st[$];
    #1;
    n_cmp++;
    if (obs() !== BUB || stall !== 1'b0) begin
      n_bad++; $display("FAIL reset_initial: got %h stall %b want %h stall 0", obs(), stall, BUB);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    drive(mk(ILL, 0, 1, 5'd5, 32'h55, dec(0, 0, 0, 0, 0, IL), 0));
    @(posedge clk); #1;
    got = obs(); want = sb.pop_front(); n_cmp++;
    if (got !== want) begin
      n_bad++; $display("FAIL reset_prefill: got %h want %h", got, want);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== BUB || stall !== 1'b0) begin
      n_bad++; $display("FAIL reset_midrun: got %h stall %b want %h stall 0", obs(), stall, BUB);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    st.push_back(mk({6'h00, 5'd5, 5'd0, 5'd1, 5'd0, 6'h20}, 0, 0, 0, 0,
                    dec(0, 0, 32'h0820, 5'd1, 6'h20, RW), 0));
    foreach (st[i]) begin
      drive(st[i]);
      @(posedge clk); #1;
      got = obs(); want = sb.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL reset_r5_cleared: got %h want %h", got, want);
      end
    end
  endtask

  task automatic test_regfile();
    step_t st[$];
    st.push_back(mk(ILL, 0, 1, 5'd1, 32'h1111_1111, dec(0, 0, 0, 0, 0, IL), 0));
    st.push_back(mk(ILL, 0, 1, 5'd2, 32'h2222_2222, dec(0, 0, 0, 0, 0, IL), 0));
    st.push_back(mk(ILL, 0, 1, 5'd3, 32'h0000_1234, dec(0, 0, 0, 0, 0, IL), 0));
    st.push_back(mk(ILL, 0, 1, 5'd4, 32'h4444_4444, dec(0, 0, 0, 0, 0, IL), 0));
    st.push_back(mk(ILL, 0, 1, 5'd7, 32'h0000_1111, dec(0, 0, 0, 0, 0, IL), 0));
    st.push_back(mk(ILL, 0, 1, 5'd0, 32'h0000_FFFF, dec(0, 0, 0, 0, 0, IL), 0));
    st.push_back(mk({6'h00, 5'd3, 5'd0, 5'd1, 5'd0, 6'h20}, 0, 0, 0, 0,
                    dec(32'h1234, 0, 32'h0820, 5'd1, 6'h20, RW), 0));
    st.push_back(mk({6'h00, 5'd0, 5'd2, 5'd9, 5'd0, 6'h22}, 0, 0, 0, 0,
                    dec(0, 32'h2222_2222, 32'h4822, 5'd9, 6'h22, RW), 0));
    foreach (st[i]) begin
      drive(st[i]);
      @(posedge clk); #1;
      got = obs(); want = sb.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL regfile step %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_load_use();
    step_t st[$];
    logic [31:0] lw4, add6, lw2, sw2, bz2, lw5, add1;
    lw4  = {6'h02, 5'd1, 5'd4, 16'h0008};
    add6 = {6'h00, 5'd4, 5'd2, 5'd6, 5'd0, 6'h20};
    lw2  = {6'h02, 5'd0, 5'd2, 16'h0000};
    sw2  = {6'h03, 5'd0, 5'd2, 16'h0004};
    bz2  = {6'h04, 5'd0, 5'd2, 16'hFFFC};
    lw5  = {6'h02, 5'd4, 5'd5, 16'h0000};
    add1 = {6'h00, 5'd5, 5'd0, 5'd1, 5'd0, 6'h20};
    st.push_back(mk(lw4, 0, 0, 0, 0, dec(32'h1111_1111, 32'h4444_4444, 8, 5'd4, 6'h02,
                                         RW | MR | AS), 0));
    st.push_back(mk(add6, 0, 0, 0, 0, BUB, 1));
    st.push_back(mk(add6, 0, 0, 0, 0, dec(32'h4444_4444, 32'h2222_2222, 32'h3020, 5'd6,
                                          6'h20, RW), 0));
    st.push_back(mk(lw2, 0, 0, 0, 0, dec(0, 32'h2222_2222, 0, 5'd2, 6'h02, RW | MR | AS), 0));
    st.push_back(mk(sw2, 0, 0, 0, 0, BUB, 1));
    st.push_back(mk(sw2, 0, 0, 0, 0, dec(0, 32'h2222_2222, 4, 5'd0, 6'h03, MW | AS), 0));
    st.push_back(mk(lw2, 0, 0, 0, 0, dec(0, 32'h2222_2222, 0, 5'd2, 6'h02, RW | MR | AS), 0));
    st.push_back(mk(bz2, 0, 0, 0, 0, dec(0, 32'h2222_2222, 32'hFFFF_FFFC, 5'd0, 6'h04, BR), 0));
    st.push_back(mk(lw4, 0, 0, 0, 0, dec(32'h1111_1111, 32'h4444_4444, 8, 5'd4, 6'h02,
                                         RW | MR | AS), 0));
    st.push_back(mk(lw5, 0, 0, 0, 0, BUB, 1));
    st.push_back(mk(lw5, 0, 0, 0, 0, dec(32'h4444_4444, 0, 0, 5'd5, 6'h02, RW | MR | AS), 0));
    st.push_back(mk(add1, 0, 0, 0, 0, BUB, 1));
    st.push_back(mk(add1, 0, 0, 0, 0, dec(0, 0, 32'h0820, 5'd1, 6'h20, RW), 0));
    foreach (st[i]) begin
      drive(st[i]);
      #1;
      n_cmp++;
      if (stall !== st[i].es) begin
        n_bad++; $display("FAIL load_use_stall step %0d: got %b want %b", i, stall, st[i].es);
      end
      @(posedge clk); #1;
      got = obs(); want = sb.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL load_use step %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_squash();
    step_t st[$];
    logic [31:0] lw4, add6;
    lw4  = {6'h02, 5'd1, 5'd4, 16'h0008};
    add6 = {6'h00, 5'd4, 5'd2, 5'd6, 5'd0, 6'h20};
    st.push_back(mk(lw4, 0, 0, 0, 0, dec(32'h1111_1111, 32'h4444_4444, 8, 5'd4, 6'h02,
                                         RW | MR | AS), 0));
    st.push_back(mk(add6, 1, 0, 0, 0, BUB, 0));
    st.push_back(mk(add6, 0, 0, 0, 0, BUB, 0));
    st.push_back(mk(add6, 0, 0, 0, 0, dec(32'h4444_4444, 32'h2222_2222, 32'h3020, 5'd6,
                                          6'h20, RW), 0));
    st.push_back(mk(ILL, 1, 0, 0, 0, BUB, 0));
    st.push_back(mk(ILL, 1, 0, 0, 0, BUB, 0));
    st.push_back(mk(ILL, 0, 0, 0, 0, BUB, 0));
    st.push_back(mk(ILL, 0, 0, 0, 0, dec(0, 0, 0, 0, 0, IL), 0));
    foreach (st[i]) begin
      drive(st[i]);
      #1;
      n_cmp++;
      if (stall !== st[i].es) begin
        n_bad++; $display("FAIL squash_stall step %0d: got %b want %b", i, stall, st[i].es);
      end
      @(posedge clk); #1;
      got = obs(); want = sb.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL squash step %0d: got %h want %h", i, got, want);
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_decode();
    step_t st[$];
    st.push_back(mk({6'h01, 5'd1, 5'd9, 16'hFFFE}, 0, 0, 0, 0,
                    dec(32'h1111_1111, 0, 32'hFFFF_FFFE, 5'd9, 6'h01, RW | AS), 0));
    st.push_back(mk({6'h3F, 5'd2, 5'd3, 16'h1234}, 0, 0, 0, 0,
                    dec(32'h2222_2222, 32'h1234, 32'h1234, 5'd0, 6'h00, IL), 0));
    st.push_back(mk(32'h17FF_FFFF, 0, 0, 0, 0, dec(0, 0, 32'h3FF, 5'd0, 6'h05, JP), 0));
    st.push_back(mk({6'h03, 5'd1, 5'd2, 16'h8010}, 0, 0, 0, 0,
                    dec(32'h1111_1111, 32'h2222_2222, 32'hFFFF_8010, 5'd0, 6'h03, MW | AS), 0));
    foreach (st[i]) begin
      drive(st[i]);
      @(posedge clk); #1;
      got = obs(); want = sb.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL decode step %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_bypass();
    step_t st[$];
    logic [31:0] same;
`ifdef REG_BYPASS_EN
    same = 32'h0000_AAAA;
`else
    same = 32'h0000_1111;
`endif
    st.push_back(mk({6'h00, 5'd7, 5'd7, 5'd8, 5'd0, 6'h20}, 0, 1, 5'd7, 32'hAAAA,
                    dec(same, same, 32'h4020, 5'd8, 6'h20, RW), 0));
    st.push_back(mk({6'h00, 5'd7, 5'd7, 5'd8, 5'd0, 6'h20}, 0, 0, 0, 0,
                    dec(32'hAAAA, 32'hAAAA, 32'h4020, 5'd8, 6'h20, RW), 0));
    st.push_back(mk({6'h00, 5'd0, 5'd7, 5'd8, 5'd0, 6'h20}, 0, 1, 5'd0, 32'hBEEF,
                    dec(0, 32'hAAAA, 32'h4020, 5'd8, 6'h20, RW), 0));
    foreach (st[i]) begin
      drive(st[i]);
      @(posedge clk); #1;
      got = obs(); want = sb.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL bypass step %0d: got %h want %h", i, got, want);
      end
    end
    wb_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_regfile();
    test_load_use();
    test_squash();
    test_decode();
    test_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
